ptp_rtc_adj: RTL
================

PTP_RTC_ADJ -- requirements
Module: ptp_rtc_adj

Interface
- REQ-001 Parameter GAP_CYCLES, default 8: minimum idle cycles after each offset pulse. The RTC's wrap-around guard needs at least 4.
- REQ-002 Parameter MAX_STEP_NS, default 1000: largest ns magnitude per slew step. Used only when slew is compiled in.
- REQ-003 Parameter SLEW_INTERVAL, default 1024: cycles between slew steps. Used only when slew is compiled in.
- REQ-004 rtc_clk  in  1  sole clock.
- REQ-005 rtc_rst_n  in  1  synchronous, active-low reset.
- REQ-006 adj_req_i  in  1  adjustment request valid.
- REQ-007 adj_rdy_o  out  1  ready to accept a request; transfer occurs when adj_req_i and adj_rdy_o are both high.
- REQ-008 adj_sc_i  in  48  signed seconds correction.
- REQ-009 adj_ns_i  in  32  signed nanoseconds correction; any 32-bit value is allowed.
- REQ-010 sc_offset_o  out  48  signed seconds offset, drives the RTC's sc_offset_i.
- REQ-011 ns_offset_o  out  32  signed ns offset, drives the RTC's ns_offset_i.
- REQ-012 offset_valid_o  out  1  one-cycle offset pulse.
- REQ-013 adj_done_o  out  1  one-cycle completion pulse.
- REQ-014 err_o  out  1  sticky overflow flag.

Function
- REQ-015 States: IDLE, NORM, ISSUE, GAP; SLEW exists only when slew is compiled in.
- REQ-016 adj_rdy_o shall be high only in IDLE.
- REQ-017 adj_req_i outside IDLE shall be ignored.
- REQ-018 On transfer in cycle T, the block shall capture adj_sc_i/adj_ns_i into working registers and enter NORM.
- REQ-019 NORM, ns >= 1,000,000,000: in one cycle, ns -= 1e9 and sc += 1; stay in NORM.
- REQ-020 NORM, ns <= -1,000,000,000: in one cycle, ns += 1e9 and sc -= 1; stay in NORM.
- REQ-021 NORM, ns in range (and not the zero case below): enter ISSUE.
- REQ-022 Normalization shall take at most k = 2 correction cycles.
- REQ-023 Boundaries: ns = 999,999,999 is in range; ns = ±1,000,000,000 is corrected.
- REQ-024 NORM: if a 48-bit signed sc increment/decrement overflows, the block shall set err_o, issue no pulse, pulse adj_done_o and return to IDLE.
- REQ-025 NORM: if the normalized sc and ns are both 0, the block shall issue no pulse, pulse adj_done_o and return to IDLE.
- REQ-026 ISSUE: offset_valid_o shall be 1 for exactly one cycle, at cycle T+2+k, with sc_offset_o/ns_offset_o carrying the normalized values in that cycle.
- REQ-027 sc_offset_o/ns_offset_o shall hold stable from the pulse until the next pulse; the RTC may defer the pulse and sample later.
- REQ-028 GAP: the block shall count GAP_CYCLES cycles; on the last one it shall pulse adj_done_o and return to IDLE, so adj_rdy_o is high the following cycle.
- REQ-029 Two offset_valid_o pulses shall never be fewer than GAP_CYCLES+1 cycles apart.
- REQ-030 ns-sign and sc-sign may differ; no cross-sign normalization shall be performed (the RTC borrows).
- REQ-031 err_o shall be cleared only by reset or by the next accepted request.

Reset
- REQ-032 While rtc_rst_n is low at a rising edge: state = IDLE; adj_rdy_o = 1; offset_valid_o = adj_done_o = err_o = 0; sc_offset_o = ns_offset_o = 0; all counters = 0.
- REQ-033 Reset asserted mid-NORM/GAP/SLEW shall abort the operation with no further pulse.

Configuration
- REQ-034 Macro PTP_RTC_ADJ_SLEW_EN.
- REQ-035 Macro defined, normalized sc = 0 and |ns| > MAX_STEP_NS: the block shall enter SLEW and issue steps of ±MAX_STEP_NS (sign of ns) with the remainder as the last step. Steps are spaced SLEW_INTERVAL cycles, which must be >= GAP_CYCLES+1. After the last step the GAP rules apply. Nonzero sc or small ns uses single-step ISSUE.
- REQ-036 Macro undefined: SLEW state and parameters are absent; every adjustment is a single pulse.

Verification
- REQ-037 sc=5, ns=300 at T -> one pulse at T+2 with sc_offset_o=5, ns_offset_o=300; adj_done_o at T+2+GAP_CYCLES; adj_rdy_o high next cycle.
- REQ-038 sc=0, ns=1,500,000,000 -> pulse at T+3 with sc_offset_o=1, ns_offset_o=500,000,000.
- REQ-039 sc=0, ns=-2,100,000,000 -> pulse at T+4 with sc_offset_o=-2, ns_offset_o=-100,000,000.
- REQ-040 sc=0x7FFF_FFFF_FFFF, ns=1,000,000,000 -> err_o=1, no pulse, adj_done_o pulses; then sc=0, ns=0 -> err_o=0, adj_done_o, no pulse.
- REQ-041 adj_req_i held high during GAP -> ignored until adj_rdy_o=1; rtc_rst_n low mid-GAP -> outputs at reset values next cycle.
- REQ-042 Slew compiled in, ns=2500, MAX_STEP_NS=1000 -> pulses ns_offset_o = 1000, 1000, 500, SLEW_INTERVAL apart, sc_offset_o=0.

Source files
------------

// File: rtl/ptp_rtc_adj.sv
// Turns a seconds/nanoseconds correction request into one normalized offset pulse for the RTC.
// Define PTP_RTC_ADJ_SLEW_EN to split large seconds-free corrections into bounded slew steps.
module ptp_rtc_adj #(
   parameter int GAP_CYCLES = 8
`ifdef PTP_RTC_ADJ_SLEW_EN
   ,
   parameter int MAX_STEP_NS   = 1000,
   parameter int SLEW_INTERVAL = 1024
`endif
) (
   input  logic        rtc_clk,
   input  logic        rtc_rst_n,
   input  logic        adj_req_i,
   output logic        adj_rdy_o,
   input  logic [47:0] adj_sc_i,
   input  logic [31:0] adj_ns_i,
   output logic [47:0] sc_offset_o,
   output logic [31:0] ns_offset_o,
   output logic        offset_valid_o,
   output logic        adj_done_o,
   output logic        err_o
);

   // Handshake: a request transfers on any rising edge where adj_req_i && adj_rdy_o;
   // adj_rdy_o is high only in IDLE and requests in other states are ignored.
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_NORM  = 3'd1,
      S_ISSUE = 3'd2,
      S_GAP   = 3'd3
`ifdef PTP_RTC_ADJ_SLEW_EN
      ,
      S_SLEW  = 3'd4
`endif
   } state_t;

   localparam logic signed [31:0] NS_PER_S = 32'sd1000000000;
   localparam logic signed [47:0] SC_MAX   = 48'sh7FFF_FFFF_FFFF;
   localparam logic signed [47:0] SC_MIN   = 48'sh8000_0000_0000;
   localparam logic [31:0]        GAP_LAST = 32'(GAP_CYCLES);

   state_t             state_q;
   logic signed [47:0] sc_q;
   logic signed [31:0] ns_q;
   logic [31:0]        cnt_q;
   logic [47:0]        sc_off_q;
   logic [31:0]        ns_off_q;
   logic               valid_q;
   logic               done_q;
   logic               err_q;

`ifdef PTP_RTC_ADJ_SLEW_EN
   localparam logic signed [31:0] STEP_MAX  = 32'(MAX_STEP_NS);
   localparam logic [31:0]        SLEW_LAST = 32'(SLEW_INTERVAL);

   logic signed [31:0] step_d;
   logic               big_ns_d;

   always_comb begin
      step_d   = ns_q;
      big_ns_d = (ns_q > STEP_MAX) || (ns_q < -STEP_MAX);
      if (ns_q > STEP_MAX)
         step_d = STEP_MAX;
      else if (ns_q < -STEP_MAX)
         step_d = -STEP_MAX;
   end
`endif

   always_ff @(posedge rtc_clk) begin
      if (!rtc_rst_n) begin
         state_q  <= S_IDLE;
         sc_q     <= '0;
         ns_q     <= '0;
         cnt_q    <= '0;
         sc_off_q <= '0;
         ns_off_q <= '0;
         valid_q  <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (adj_req_i) begin
                  sc_q    <= adj_sc_i;
                  ns_q    <= adj_ns_i;
                  err_q   <= 1'b0;
                  state_q <= S_NORM;
               end
            end
            S_NORM: begin
               if (ns_q >= NS_PER_S) begin
                  if (sc_q == SC_MAX) begin
                     err_q   <= 1'b1;
                     done_q  <= 1'b1;
                     state_q <= S_IDLE;
                  end else begin
                     ns_q <= ns_q - NS_PER_S;
                     sc_q <= sc_q + 48'sd1;
                  end
               end else if (ns_q <= -NS_PER_S) begin
                  if (sc_q == SC_MIN) begin
                     err_q   <= 1'b1;
                     done_q  <= 1'b1;
                     state_q <= S_IDLE;
                  end else begin
                     ns_q <= ns_q + NS_PER_S;
                     sc_q <= sc_q - 48'sd1;
                  end
               end else if (sc_q == '0 && ns_q == '0) begin
                  done_q  <= 1'b1;
                  state_q <= S_IDLE;
`ifdef PTP_RTC_ADJ_SLEW_EN
               end else if (sc_q == '0 && big_ns_d) begin
                  valid_q  <= 1'b1;
                  sc_off_q <= '0;
                  ns_off_q <= step_d;
                  ns_q     <= ns_q - step_d;
                  cnt_q    <= 32'd1;
                  state_q  <= S_SLEW;
`endif
               end else begin
                  valid_q  <= 1'b1;
                  sc_off_q <= sc_q;
                  ns_off_q <= ns_q;
                  state_q  <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               cnt_q   <= 32'd1;
               state_q <= S_GAP;
            end
            S_GAP: begin
               // The RTC's wrap-around guard needs this quiet time after every pulse.
               if (cnt_q == GAP_LAST - 32'd1)
                  done_q <= 1'b1;
               if (cnt_q >= GAP_LAST) begin
                  cnt_q   <= '0;
                  state_q <= S_IDLE;
               end else begin
                  cnt_q <= cnt_q + 32'd1;
               end
            end
`ifdef PTP_RTC_ADJ_SLEW_EN
            S_SLEW: begin
               if (cnt_q >= SLEW_LAST) begin
                  valid_q  <= 1'b1;
                  ns_off_q <= step_d;
                  ns_q     <= ns_q - step_d;
                  cnt_q    <= 32'd1;
                  if (step_d == ns_q)
                     state_q <= S_ISSUE;
               end else begin
                  cnt_q <= cnt_q + 32'd1;
               end
            end
`endif
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign adj_rdy_o      = (state_q == S_IDLE);
   assign sc_offset_o    = sc_off_q;
   assign ns_offset_o    = ns_off_q;
   assign offset_valid_o = valid_q;
   assign adj_done_o     = done_q;
   assign err_o          = err_q;

endmodule
